frame_stimulus_gen: RTL and testbench

//   Parametrised stimulus/harness block that drives `system` from a top level with a raster-timed pixel stream.

---
 rtl/frame_stim_pkg.sv | 30 +++
 rtl/stim_misr.sv | 33 +++
 rtl/frame_stimulus_gen.sv | 193 +++++++++++++++++++
 tb/tb_frame_stimulus_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_stim_pkg.sv
// Shared encodings and LFSR/MISR step functions for frame_stimulus_gen.
// The signature feature is guarded by the FRAME_STIM_SIG_EN macro in the top file.
package frame_stim_pkg;

    localparam logic [1:0] MODE_LFSR     = 2'd0;
    localparam logic [1:0] MODE_RAMP     = 2'd1;
    localparam logic [1:0] MODE_FEEDBACK = 2'd2;
    localparam logic [1:0] MODE_CONST    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } stim_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Tap masks: LFSR feedback bits 0,2,3,5; MISR feedback bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] MISR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m);
        return {m[14:0], ^(m & MISR_TAPS)};
    endfunction

endpackage

// File: rtl/stim_misr.sv
// 16-bit MISR: clr restarts from zero, and a word presented with en in the
// same cycle folds into that fresh state.
module stim_misr
    import frame_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic [15:0] sig_base;

    always_comb begin
        sig_base = clr ? 16'h0000 : sig_q;
        sig_d    = en ? (misr_step(sig_base) ^ din) : sig_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/frame_stimulus_gen.sv
// Raster-timed pixel stimulus generator with per-frame match signature.
// Define FRAME_STIM_SIG_EN to build the MISR, signature and match_count.
module frame_stimulus_gen
    import frame_stim_pkg::*;
#(
    parameter int          IM_WIDTH  = 640,
    parameter int          IM_HEIGHT = 480,
    parameter int          H_BLANK   = 16,
    parameter int          V_BLANK   = 32,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] CONST_VAL = 16'h005A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              new_frame,
    input  logic              match_flag,
    input  logic [11:0]       match_xs,
    input  logic [11:0]       match_ys,
    input  logic [11:0]       match_xe,
    input  logic [11:0]       match_ye,
    input  logic [9:0]        match_span,
    output logic [15:0]       signature,
    output logic [15:0]       match_count,
    output logic [15:0]       frame_count,
    output logic [1:0]        dbg_state
);

    localparam logic [15:0] X_LAST = 16'(IM_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IM_HEIGHT - 1);
    localparam logic [15:0] H_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] V_LAST = 16'(V_BLANK - 1);

    stim_state_e       state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d, cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d, fb_q, fb_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              new_frame_q, new_frame_d;
    logic              start;
    logic [15:0]       ramp_sum;

    // Outputs are registered from next-state values, so every *_d here
    // describes the pixel that will be presented in the following cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) start = 1'b1;
            end
            ST_ACTIVE: begin
                if (x_q == X_LAST) begin
                    x_d     = 16'h0000;
                    cnt_d   = 16'h0000;
                    state_d = (y_q == Y_LAST) ? ST_VBLANK : ST_HBLANK;
                end else begin
                    x_d = x_q + 16'h0001;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == H_LAST) begin
                    state_d = ST_ACTIVE;
                    y_d     = y_q + 16'h0001;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == V_LAST) begin
                    if (enable) start = 1'b1;
                    else        state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_ACTIVE;
            x_d     = 16'h0000;
            y_d     = 16'h0000;
        end

        fb_d = fb_q ^ {4'b0, match_xs} ^ {4'b0, match_ys} ^ {4'b0, match_xe}
                    ^ {4'b0, match_ye} ^ {6'b0, match_span} ^ {15'b0, match_flag};
        mode_d = start ? mode : mode_q;
        if (start)                    lfsr_d = LFSR_SEED;
        else if (state_q == ST_ACTIVE) lfsr_d = lfsr_step(lfsr_q);
        else                          lfsr_d = lfsr_q;
        ramp_sum = x_d + y_d;

        data_valid_d = (state_d == ST_ACTIVE);
        data_out_d   = '0;
        if (data_valid_d) begin
            case (mode_d)
                MODE_LFSR:     data_out_d = lfsr_d[DATA_W-1:0];
                MODE_RAMP:     data_out_d = ramp_sum[DATA_W-1:0];
                MODE_FEEDBACK: data_out_d = fb_d[DATA_W-1:0];
                default:       data_out_d = CONST_VAL[DATA_W-1:0];
            endcase
        end
        new_frame_d   = start;
        frame_count_d = frame_count_q + {15'b0, start};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            x_q           <= 16'h0000;
            y_q           <= 16'h0000;
            cnt_q         <= 16'h0000;
            lfsr_q        <= LFSR_SEED;
            fb_q          <= 16'h0000;
            mode_q        <= MODE_LFSR;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            new_frame_q   <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            fb_q          <= fb_d;
            mode_q        <= mode_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            new_frame_q   <= new_frame_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign new_frame   = new_frame_q;
    assign frame_count = frame_count_q;
    assign dbg_state   = state_q;

`ifdef FRAME_STIM_SIG_EN
    logic [15:0] misr_in, misr_sig;
    logic [15:0] mcnt_q, mcnt_d, mcnt_base;
    logic [15:0] signature_q, signature_d, match_count_q, match_count_d;

    stim_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (new_frame_q),
        .en  (match_flag),
        .din (misr_in),
        .sig (misr_sig)
    );

    // The new_frame cycle publishes the previous frame and restarts the
    // accumulators; a match in that cycle belongs to the new frame.
    always_comb begin
        misr_in = {4'b0, match_xs} ^ {match_ys, 4'b0} ^ {4'b0, match_xe}
                ^ {match_ye, 4'b0} ^ {6'b0, match_span};
        mcnt_base = new_frame_q ? 16'h0000 : mcnt_q;
        mcnt_d    = (match_flag && (mcnt_base != 16'hFFFF)) ? mcnt_base + 16'h0001 : mcnt_base;
        signature_d   = new_frame_q ? misr_sig : signature_q;
        match_count_d = new_frame_q ? mcnt_q   : match_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt_q        <= 16'h0000;
            signature_q   <= 16'h0000;
            match_count_q <= 16'h0000;
        end else begin
            mcnt_q        <= mcnt_d;
            signature_q   <= signature_d;
            match_count_q <= match_count_d;
        end
    end

    assign signature   = signature_q;
    assign match_count = match_count_q;
`else
    assign signature   = 16'h0000;
    assign match_count = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_stimulus_gen.sv
// Directed bench for frame_stimulus_gen with a 4x2 raster, H_BLANK=2, V_BLANK=3.
// Signature expectations follow whether FRAME_STIM_SIG_EN is defined.
module tb_frame_stimulus_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  data_out;
    logic        data_valid, new_frame;
    logic        match_flag = 1'b0;
    logic [11:0] match_xs = '0, match_ys = '0, match_xe = '0, match_ye = '0;
    logic [9:0]  match_span = '0;
    logic [15:0] signature, match_count, frame_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  lfsr_exp [8];
    logic [7:0]  ramp_exp [8];
    logic [12:0] vpat;
    int          pix;

    frame_stimulus_gen #(
        .IM_WIDTH (4),
        .IM_HEIGHT(2),
        .H_BLANK  (2),
        .V_BLANK  (3),
        .DATA_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .data_out   (data_out),
        .data_valid (data_valid),
        .new_frame  (new_frame),
        .match_flag (match_flag),
        .match_xs   (match_xs),
        .match_ys   (match_ys),
        .match_xe   (match_xe),
        .match_ye   (match_ye),
        .match_span (match_span),
        .signature  (signature),
        .match_count(match_count),
        .frame_count(frame_count),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_new_frame(input string tag);
        int n = 0;
        while (!new_frame && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_new_frame"}, 32'(new_frame), 32'd1);
    endtask

    task automatic check_frame_start(input string tag, input logic [15:0] fc, input logic [7:0] px);
        check({tag, "_nf"},    32'(new_frame),   32'd1);
        check({tag, "_valid"}, 32'(data_valid),  32'd1);
        check({tag, "_fc"},    32'(frame_count), 32'(fc));
        check({tag, "_data"},  32'(data_out),    32'(px));
    endtask

    task automatic check_sig(input string tag, input logic [15:0] sig, input logic [15:0] cnt);
`ifdef FRAME_STIM_SIG_EN
        check({tag, "_sig"}, 32'(signature),   32'(sig));
        check({tag, "_cnt"}, 32'(match_count), 32'(cnt));
`else
        check({tag, "_sig"}, 32'(signature),   32'd0);
        check({tag, "_cnt"}, 32'(match_count), 32'd0);
`endif
    endtask

    initial begin
        lfsr_exp = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'hCE, 8'h67, 8'hB3, 8'h59};
        ramp_exp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
        vpat     = 13'b1111_00_1111_000;

        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(data_valid),  32'd0);
        check("rst_data",  32'(data_out),    32'd0);
        check("rst_nf",    32'(new_frame),   32'd0);
        check("rst_fc",    32'(frame_count), 32'd0);
        check("rst_state", 32'(dbg_state),   32'd0);
        check_sig("rst", 16'h0000, 16'h0000);
        rst    = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;

        // LFSR frame: pixel values and the 13-cycle valid pattern
        tick();
        check_frame_start("lfsr_f1", 16'd1, 8'hE1);
        pix = 0;
        for (int i = 0; i < 13; i++) begin
            check($sformatf("lfsr_valid_%0d", i), 32'(data_valid), 32'(vpat[12-i]));
            if (vpat[12-i]) begin
                check($sformatf("lfsr_px_%0d", pix), 32'(data_out), 32'(lfsr_exp[pix]));
                pix++;
            end else begin
                check($sformatf("lfsr_blank_%0d", i), 32'(data_out), 32'd0);
            end
            tick();
        end
        check_frame_start("lfsr_f2", 16'd2, 8'hE1);
        for (int i = 0; i < 13; i++) tick();
        check_frame_start("lfsr_f3", 16'd3, 8'hE1);

        // Mid-frame switch to ramp is ignored until the next frame
        mode = 2'd1;
        tick();
        check("lfsr_hold_mode", 32'(data_out), 32'h70);
        wait_new_frame("ramp");
        check_frame_start("ramp_f4", 16'd4, 8'h00);
        pix = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) mode = 2'd2;
            check($sformatf("ramp_valid_%0d", i), 32'(data_valid), 32'(vpat[12-i]));
            if (vpat[12-i]) begin
                check($sformatf("ramp_px_%0d", pix), 32'(data_out), 32'(ramp_exp[pix]));
                pix++;
            end
            tick();
        end

        // Feedback frame: register stays 0 until a single match pulse
        check_frame_start("fb_f5", 16'd5, 8'h00);
        mode       = 2'd3;
        match_flag = 1'b1;
        tick();
        match_flag = 1'b0;
        check("fb_px1", 32'(data_out), 32'h01);
        tick();
        check("fb_px2", 32'(data_out), 32'h01);

        // Constant frame; previous frame held one match whose word was 0
        wait_new_frame("const");
        check_frame_start("const_f6", 16'd6, 8'h5A);
        tick();
        check_sig("f6", 16'h0000, 16'h0001);
        match_flag = 1'b1;
        match_xs   = 12'h001;
        tick();
        match_flag = 1'b0;
        match_xs   = 12'h000;
        wait_new_frame("sig1");
        tick();
        check_sig("f7", 16'h0001, 16'h0001);
        wait_new_frame("sig0");
        tick();
        check_sig("f8", 16'h0000, 16'h0000);

        // Enable dropped at pixel (1,0): frame completes, then IDLE
        enable = 1'b0;
        for (int i = 1; i < 13; i++) begin
            check($sformatf("drop_valid_%0d", i), 32'(data_valid), 32'(vpat[12-i]));
            check($sformatf("drop_data_%0d", i), 32'(data_out), vpat[12-i] ? 32'h5A : 32'h0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("idle_valid_%0d", i), 32'(data_valid), 32'd0);
            check($sformatf("idle_nf_%0d", i),    32'(new_frame),  32'd0);
            check($sformatf("idle_state_%0d", i), 32'(dbg_state),  32'd0);
            tick();
        end
        check("idle_fc", 32'(frame_count), 32'd8);

        // Re-enable, then reset asynchronously in the middle of a frame
        enable = 1'b1;
        mode   = 2'd0;
        tick();
        check_frame_start("reen_f9", 16'd9, 8'hE1);
        tick();
        tick();
        check("reen_px2", 32'(data_out), 32'h38);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(data_valid),  32'd0);
        check("arst_data",  32'(data_out),    32'd0);
        check("arst_nf",    32'(new_frame),   32'd0);
        check("arst_fc",    32'(frame_count), 32'd0);
        check_sig("arst", 16'h0000, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check_frame_start("post_rst", 16'd1, 8'hE1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
